// File: rtl/tlp_tx_arbiter.sv
// tlp_tx_arbiter: round-robin arbiter sharing the root-port TLP packet
// generator between NUM_REQ requesters. Each issued TLP gets the next 8-bit
// tag. Requesters see a one-cycle accept pulse and a completion/abort pulse.
// Optional macro TX_ARB_TIMEOUT_EN adds a tx_done watchdog of TIMEOUT_CYCLES.
module tlp_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   user_clk,
  input  logic                   reset_n,
  input  logic                   user_lnk_up,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [3*NUM_REQ-1:0]   req_type,
  input  logic [64*NUM_REQ-1:0]  req_addr,
  input  logic [128*NUM_REQ-1:0] req_data,
  input  logic [11*NUM_REQ-1:0]  req_length,
  output logic [NUM_REQ-1:0]     req_ack,
  output logic [NUM_REQ-1:0]     req_done,
  output logic                   req_err,
  output logic [7:0]             req_tag,
  output logic [2:0]             tx_type,
  output logic [7:0]             tx_tag,
  output logic [63:0]            tx_addr,
  output logic [127:0]           tx_data,
  output logic [10:0]            tx_length,
  output logic                   tx_start,
  input  logic                   tx_done,
  output logic                   tx_timeout,
  output logic [1:0]             arb_state
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_DONE = 2'd1,
    ST_ABORT     = 2'd2
  } state_t;

  state_t          state_reg, state_next;
  logic [PW-1:0]   rr_ptr_reg;
  logic [PW-1:0]   owner_reg;
  logic [PW-1:0]   owner_inc;
  logic [PW-1:0]   win_idx;
  logic [PW:0]     cand_sum;
  logic [PW-1:0]   cand_idx;
  logic            win_found;
  logic            grant;
  logic            timeout_hit;

  // Per-requester views of the flattened request buses
  logic [2:0]   type_arr [NUM_REQ];
  logic [63:0]  addr_arr [NUM_REQ];
  logic [127:0] data_arr [NUM_REQ];
  logic [10:0]  len_arr  [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign type_arr[gi] = req_type[3*gi +: 3];
      assign addr_arr[gi] = req_addr[64*gi +: 64];
      assign data_arr[gi] = req_data[128*gi +: 128];
      assign len_arr[gi]  = req_length[11*gi +: 11];
    end
  endgenerate

  // Winner: first requesting index at or above rr_ptr, wrapping at NUM_REQ
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand_sum  = '0;
    cand_idx  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_sum = {1'b0, rr_ptr_reg} + (PW+1)'(k);
      if (cand_sum >= (PW+1)'(NUM_REQ)) begin
        cand_sum = cand_sum - (PW+1)'(NUM_REQ);
      end
      cand_idx = cand_sum[PW-1:0];
      if (!win_found && req_valid[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  assign grant     = (state_reg == ST_IDLE) && user_lnk_up && win_found;
  assign owner_inc = (owner_reg == PW'(NUM_REQ-1)) ? '0 : owner_reg + PW'(1);

  // State register
  always_ff @(posedge user_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; a tx_done in the same cycle as link loss completes normally
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (grant) state_next = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (tx_done)           state_next = ST_IDLE;
        else if (!user_lnk_up) state_next = ST_ABORT;
        else if (timeout_hit)  state_next = ST_ABORT;
      end
      ST_ABORT: state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Output decode: debug state mirrors the FSM
  assign arb_state = state_reg;

  // Registered outputs: grant capture, tag allocation, done/abort pulses
  always_ff @(posedge user_clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_reg <= '0;
      owner_reg  <= '0;
      tx_start   <= 1'b0;
      tx_type    <= '0;
      tx_tag     <= '0;
      tx_addr    <= '0;
      tx_data    <= '0;
      tx_length  <= '0;
      req_ack    <= '0;
      req_done   <= '0;
      req_err    <= 1'b0;
      req_tag    <= '0;
    end else begin
      tx_start <= 1'b0;
      req_ack  <= '0;
      req_done <= '0;
      req_err  <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (grant) begin
            tx_type   <= type_arr[win_idx];
            tx_addr   <= addr_arr[win_idx];
            tx_data   <= data_arr[win_idx];
            tx_length <= len_arr[win_idx];
            tx_tag    <= tx_tag + 8'd1;
            req_tag   <= tx_tag + 8'd1;
            tx_start  <= 1'b1;
            req_ack   <= NUM_REQ'(1) << win_idx;
            owner_reg <= win_idx;
          end
        end
        ST_WAIT_DONE: begin
          if (tx_done) begin
            req_done   <= NUM_REQ'(1) << owner_reg;
            rr_ptr_reg <= owner_inc;
          end
        end
        ST_ABORT: begin
          req_done   <= NUM_REQ'(1) << owner_reg;
          req_err    <= 1'b1;
          rr_ptr_reg <= owner_inc;
        end
        default: ;
      endcase
    end
  end

`ifdef TX_ARB_TIMEOUT_EN
  logic [15:0] wd_cnt_reg;

  assign timeout_hit = (state_reg == ST_WAIT_DONE) && !tx_done &&
                       (wd_cnt_reg == 16'(TIMEOUT_CYCLES-1));

  // Watchdog: cleared on grant, counts every cycle spent waiting for tx_done
  always_ff @(posedge user_clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt_reg <= '0;
    end else if (grant) begin
      wd_cnt_reg <= '0;
    end else if (state_reg == ST_WAIT_DONE) begin
      wd_cnt_reg <= wd_cnt_reg + 16'd1;
    end
  end

  // Sticky timeout flag, cleared only by reset
  always_ff @(posedge user_clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_timeout <= 1'b0;
    end else if (timeout_hit) begin
      tx_timeout <= 1'b1;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign timeout_hit        = 1'b0;
  assign tx_timeout         = 1'b0;
`endif

endmodule

// File: tb/tb_tlp_tx_arbiter.sv
// Self-checking bench for tlp_tx_arbiter: directed stimulus pushes expected
// issue/done events into a scoreboard queue; a negedge monitor pops and
// compares whenever the DUT presents tx_start or req_done.
module tb_tlp_tx_arbiter;

  localparam int NUM_REQ = 4;

  logic                   user_clk = 1'b0;
  logic                   reset_n = 1'b0;
  logic                   user_lnk_up = 1'b1;
  logic [NUM_REQ-1:0]     req_valid = '0;
  logic [3*NUM_REQ-1:0]   req_type;
  logic [64*NUM_REQ-1:0]  req_addr;
  logic [128*NUM_REQ-1:0] req_data;
  logic [11*NUM_REQ-1:0]  req_length;
  logic [NUM_REQ-1:0]     req_ack;
  logic [NUM_REQ-1:0]     req_done;
  logic                   req_err;
  logic [7:0]             req_tag;
  logic [2:0]             tx_type;
  logic [7:0]             tx_tag;
  logic [63:0]            tx_addr;
  logic [127:0]           tx_data;
  logic [10:0]            tx_length;
  logic                   tx_start;
  logic                   tx_done = 1'b0;
  logic                   tx_timeout;
  logic [1:0]             arb_state;

  logic [2:0]   f_type [NUM_REQ];
  logic [63:0]  f_addr [NUM_REQ];
  logic [127:0] f_data [NUM_REQ];
  logic [10:0]  f_len  [NUM_REQ];

  typedef struct {
    bit           is_done;
    int           idx;
    logic [2:0]   typ;
    logic [63:0]  addr;
    logic [127:0] data;
    logic [10:0]  len;
    logic [7:0]   tag;
    bit           err;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  always #5 user_clk = ~user_clk;

  tlp_tx_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT_CYCLES(16)) dut (
    .user_clk   (user_clk),
    .reset_n    (reset_n),
    .user_lnk_up(user_lnk_up),
    .req_valid  (req_valid),
    .req_type   (req_type),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .req_length (req_length),
    .req_ack    (req_ack),
    .req_done   (req_done),
    .req_err    (req_err),
    .req_tag    (req_tag),
    .tx_type    (tx_type),
    .tx_tag     (tx_tag),
    .tx_addr    (tx_addr),
    .tx_data    (tx_data),
    .tx_length  (tx_length),
    .tx_start   (tx_start),
    .tx_done    (tx_done),
    .tx_timeout (tx_timeout),
    .arb_state  (arb_state)
  );

  always_comb begin
    req_type   = '0;
    req_addr   = '0;
    req_data   = '0;
    req_length = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_type[3*i +: 3]     = f_type[i];
      req_addr[64*i +: 64]   = f_addr[i];
      req_data[128*i +: 128] = f_data[i];
      req_length[11*i +: 11] = f_len[i];
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  task automatic push_issue(input int idx, input int tag);
    exp_t e;
    e.is_done = 1'b0;
    e.idx  = idx;
    e.typ  = f_type[idx];
    e.addr = f_addr[idx];
    e.data = f_data[idx];
    e.len  = f_len[idx];
    e.tag  = 8'(tag);
    e.err  = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic push_done(input int idx, input bit err);
    exp_t e;
    e.is_done = 1'b1;
    e.idx  = idx;
    e.typ  = '0;
    e.addr = '0;
    e.data = '0;
    e.len  = '0;
    e.tag  = '0;
    e.err  = err;
    exp_q.push_back(e);
  endtask

  // Scoreboard monitor
  always @(negedge user_clk) begin : mon
    exp_t e;
    if (reset_n) begin
      if (tx_start) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_fail++;
          $display("FAIL unexpected_tx_start: got tag %0d ack %b required no issue", tx_tag, req_ack);
        end else begin
          e = exp_q.pop_front();
          if (e.is_done) begin
            n_vec++; n_fail++;
            $display("FAIL order_issue: got tx_start tag %0d required req_done[%0d]", tx_tag, e.idx);
          end else begin
            $display("issue: owner %0d tag %0d type %0h addr %0h len %0d", e.idx, tx_tag, tx_type, tx_addr, tx_length);
            chk("issue_ack",  req_ack,   NUM_REQ'(1) << e.idx);
            chk("issue_tag",  tx_tag,    e.tag);
            chk("issue_rtag", req_tag,   e.tag);
            chk("issue_type", tx_type,   e.typ);
            chk("issue_addr", tx_addr,   e.addr);
            chk("issue_data", tx_data,   e.data);
            chk("issue_len",  tx_length, e.len);
          end
        end
      end
      if (req_done != '0) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_fail++;
          $display("FAIL unexpected_req_done: got %b err %0b required none", req_done, req_err);
        end else begin
          e = exp_q.pop_front();
          if (!e.is_done) begin
            n_vec++; n_fail++;
            $display("FAIL order_done: got req_done %b required issue tag %0d", req_done, e.tag);
          end else begin
            $display("done: owner %0d err %0b", e.idx, req_err);
            chk("done_vec", req_done, NUM_REQ'(1) << e.idx);
            chk("done_err", req_err,  e.err);
          end
        end
      end
    end
  end

  task automatic check_zero(input string tag_s);
    chk({tag_s, "_tx_start"},  tx_start,  0);
    chk({tag_s, "_req_ack"},   req_ack,   0);
    chk({tag_s, "_req_done"},  req_done,  0);
    chk({tag_s, "_req_err"},   req_err,   0);
    chk({tag_s, "_req_tag"},   req_tag,   0);
    chk({tag_s, "_tx_tag"},    tx_tag,    0);
    chk({tag_s, "_tx_addr"},   tx_addr,   0);
    chk({tag_s, "_tx_data"},   tx_data,   0);
    chk({tag_s, "_tx_type"},   tx_type,   0);
    chk({tag_s, "_tx_length"}, tx_length, 0);
    chk({tag_s, "_tx_timeout"},tx_timeout,0);
    chk({tag_s, "_arb_state"}, arb_state, 0);
  endtask

  task automatic wait_start();
    int n = 0;
    do begin
      @(negedge user_clk);
      n++;
    end while (!tx_start && n < 64);
    chk("tx_start_seen", tx_start, 1);
  endtask

  task automatic pulse_done();
    tx_done = 1'b1;
    @(negedge user_clk);
    tx_done = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge user_clk);
    reset_n = 1'b0;
    @(negedge user_clk);
    reset_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int starts;
    int n;
    f_type = '{3'b000, 3'b010, 3'b001, 3'b100};
    f_len  = '{11'd4, 11'd2, 11'd1, 11'd16};
    for (int i = 0; i < NUM_REQ; i++) begin
      f_addr[i] = 64'h10_0000_1000 + 64'(4*i);
      f_data[i] = {32'hDEAD_0000 + 32'(i), 32'hBEEF_0000 + 32'(i),
                   32'h1234_0000 + 32'(i), 32'hCAFE_0000 + 32'(i)};
    end

    // Reset state
    repeat (3) @(negedge user_clk);
    check_zero("rst_held");
    reset_n = 1'b1;
    @(negedge user_clk);
    check_zero("rst_idle");

    // Single request from requester 2
    req_valid[2] = 1'b1;
    push_issue(2, 1);
    push_done(2, 1'b0);
    wait_start();
    req_valid[2] = 1'b0;
    repeat (4) @(negedge user_clk);
    pulse_done();
    repeat (3) @(negedge user_clk);

    // Contention from a fresh reset: order 0,1,2,3,0 with tags 1..5
    do_reset();
    push_issue(0, 1); push_done(0, 1'b0);
    push_issue(1, 2); push_done(1, 1'b0);
    push_issue(2, 3); push_done(2, 1'b0);
    push_issue(3, 4); push_done(3, 1'b0);
    push_issue(0, 5); push_done(0, 1'b0);
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_start();
      if (k == 4) req_valid = '0;
      repeat (2) @(negedge user_clk);
      pulse_done();
    end
    repeat (3) @(negedge user_clk);

    // Link drop two cycles after tx_start: abort, then hold off grants
    req_valid[1] = 1'b1;
    push_issue(1, 6);
    push_done(1, 1'b1);
    wait_start();
    req_valid[1] = 1'b0;
    repeat (2) @(negedge user_clk);
    user_lnk_up  = 1'b0;
    req_valid[3] = 1'b1;
    push_issue(3, 7);
    push_done(3, 1'b0);
    starts = 0;
    repeat (8) begin
      @(negedge user_clk);
      if (tx_start) starts++;
    end
    chk("no_start_link_down", starts, 0);
    user_lnk_up = 1'b1;
    wait_start();
    req_valid[3] = 1'b0;
    repeat (2) @(negedge user_clk);
    pulse_done();
    repeat (3) @(negedge user_clk);

    // tx_done and link loss together: completion wins
    req_valid[0] = 1'b1;
    push_issue(0, 8);
    push_done(0, 1'b0);
    wait_start();
    req_valid[0] = 1'b0;
    @(negedge user_clk);
    tx_done     = 1'b1;
    user_lnk_up = 1'b0;
    @(negedge user_clk);
    tx_done     = 1'b0;
    user_lnk_up = 1'b1;
    repeat (3) @(negedge user_clk);

    // Stray tx_done while idle is ignored
    pulse_done();
    repeat (3) @(negedge user_clk);
    chk("idle_after_stray_done", arb_state, 0);

    // Withdrawn request while busy is never granted
    req_valid[2] = 1'b1;
    push_issue(2, 9);
    push_done(2, 1'b0);
    wait_start();
    req_valid[2] = 1'b0;
    @(negedge user_clk);
    req_valid[0] = 1'b1;
    repeat (2) @(negedge user_clk);
    req_valid[0] = 1'b0;
    @(negedge user_clk);
    pulse_done();
    repeat (6) @(negedge user_clk);

    // Tag wrap: 256 back-to-back requests from requester 0, tags end 255, 0
    do_reset();
    for (int k = 1; k <= 256; k++) begin
      push_issue(0, k % 256);
      push_done(0, 1'b0);
    end
    req_valid[0] = 1'b1;
    for (int k = 0; k < 256; k++) begin
      wait_start();
      if (k == 255) req_valid[0] = 1'b0;
      pulse_done();
    end
    repeat (3) @(negedge user_clk);
    chk("wrap_final_tag", tx_tag, 0);

    // Asynchronous reset in ST_WAIT_DONE drops the owner silently
    req_valid[1] = 1'b1;
    push_issue(1, 1);
    wait_start();
    req_valid[1] = 1'b0;
    repeat (2) @(negedge user_clk);
    chk("busy_before_reset", arb_state, 1);
    reset_n = 1'b0;
    #1;
    check_zero("async_rst");
    @(negedge user_clk);
    reset_n = 1'b1;
    repeat (2) @(negedge user_clk);
    pulse_done();
    repeat (3) @(negedge user_clk);

`ifdef TX_ARB_TIMEOUT_EN
    // Watchdog: no tx_done, abort reported 17 cycles after tx_start is seen
    req_valid[0] = 1'b1;
    push_issue(0, 1);
    push_done(0, 1'b1);
    wait_start();
    req_valid[0] = 1'b0;
    n = 0;
    do begin
      @(negedge user_clk);
      n++;
    end while (req_done == '0 && n < 40);
    chk("timeout_latency", n, 17);
    chk("timeout_flag", tx_timeout, 1);
    repeat (2) @(negedge user_clk);
    pulse_done();
    repeat (3) @(negedge user_clk);
    chk("timeout_sticky", tx_timeout, 1);
`else
    n = 0;
    chk("timeout_tied_low", tx_timeout, n);
`endif

    @(negedge user_clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
